// File: rtl/uart_transmitter.sv
// uart_transmitter: 16x-oversampled UART TX with a one-byte holding register.
// Optional parity is compiled in with `define UART_TX_PARITY_EN (PARITY_ODD sets sense).
// Ports: clk_50m, rst (async, active-high), clken (16x tick), tx_en (0 = run),
//   din/wr_en (byte write), ovr_clr; tx, tx_busy, hold_full, overrun (all registered).
module uart_transmitter #(
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic       clken,
  input  logic       tx_en,
  input  logic [7:0] din,
  input  logic       wr_en,
  input  logic       ovr_clr,
  output logic       tx,
  output logic       tx_busy,
  output logic       hold_full,
  output logic       overrun
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] sample_q, sample_d;
  logic [2:0] bitpos_q, bitpos_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic       overrun_q, overrun_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;

  logic tick;
  logic bit_end;
  logic stop_end;
  logic load;
  logic par_bit;

  assign tick     = clken & ~tx_en;
  assign bit_end  = tick & (sample_q == 4'd15);
  // bitpos doubles as the stop-bit counter while in STOP
  assign stop_end = bit_end & (bitpos_q == 3'(STOP_BITS - 1));

  // Holding register hands over to the shifter from IDLE or at the end of STOP
  assign load = hold_full_q &
                (((state_q == S_IDLE) & tick) |
                 ((state_q == S_STOP) & stop_end));

  // Only reachable through the PARITY state, which exists only with the macro
  assign par_bit = (^shift_d) ^ (PARITY_ODD != 0);

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sample_q    <= 4'd0;
      bitpos_q    <= 3'd0;
      shift_q     <= 8'd0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      overrun_q   <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sample_q    <= sample_d;
      bitpos_q    <= bitpos_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      overrun_q   <= overrun_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    bitpos_d = bitpos_q;
    shift_d  = shift_q;
    if (tick) sample_d = sample_q + 4'd1;
    case (state_q)
      S_IDLE: begin
        sample_d = 4'd0;
        bitpos_d = 3'd0;
        if (load) begin
          state_d = S_START;
          shift_d = hold_q;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d  = S_DATA;
          bitpos_d = 3'd0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          bitpos_d = bitpos_q + 3'd1;
          if (bitpos_q == 3'd7) begin
            bitpos_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d  = S_STOP;
          bitpos_d = 3'd0;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          bitpos_d = bitpos_q + 3'd1;
          if (stop_end) begin
            bitpos_d = 3'd0;
            if (hold_full_q) begin
              state_d = S_START;
              shift_d = hold_q;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        sample_d = 4'd0;
        bitpos_d = 3'd0;
      end
    endcase
  end

  // A write coinciding with a load is accepted, so hold_full stays set
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    overrun_d   = overrun_q;
    if (ovr_clr) overrun_d = 1'b0;
    if (load) hold_full_d = 1'b0;
    if (wr_en) begin
      if (!hold_full_q || load) begin
        hold_d      = din;
        hold_full_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // Line value is decoded from the next state so tx is a plain flop
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[bitpos_d];
      S_PARITY: tx_d = par_bit;
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx        = tx_q;
  assign tx_busy   = busy_q;
  assign hold_full = hold_full_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Serial UART transmitter. Mirror of the existing UART receiver.
- Frames a byte as 1 start bit (low), 8 data bits LSB first, an optional parity bit, and STOP_BITS stop bits (high).
- Uses the same 16x oversampling `clken` as the receiver, so both share one baud generator.
- A one-byte holding register in front of the shift register allows back-to-back frames with no idle gap.

Parameters:
- STOP_BITS, 1, number of stop bits; legal values are 1 or 2.
- PARITY_ODD, 0, parity sense when UART_TX_PARITY_EN is defined: 0 = even, 1 = odd. Ignored otherwise.

Ports:
- clk_50m  input  1  50 MHz system clock
- rst  input  1  asynchronous reset, active-high
- clken  input  1  16x baud sample enable, one-cycle pulses
- tx_en  input  1  transmitter enable, active-low (0 = run), same polarity as the receiver's rx_en
- din  input  8  byte to transmit
- wr_en  input  1  write strobe for din, one cycle
- ovr_clr  input  1  clears the overrun flag
- tx  output  1  serial output line
- tx_busy  output  1  high while a frame is on the line
- hold_full  output  1  holding register occupied; a writer may write only when this is low
- overrun  output  1  sticky flag: a write arrived while the holding register was full

Behaviour:
- Reset (async, rst=1): tx=1, tx_busy=0, hold_full=0, overrun=0, state=IDLE, sample=0, bitpos=0.
- All outputs are registered.
- A "tick" is a clk_50m cycle with clken=1 and tx_en=0.
  - When tx_en=1, ticks are ignored. The FSM, the counters and tx hold their values (the frame pauses).
  - Writes, ovr_clr and the holding-register handshake stay active when tx_en=1.
- Write, wr_en=1 with hold_full=0: din is captured into the holding register; hold_full=1 on the next cycle.
- Write, wr_en=1 with hold_full=1: the data is dropped, the holding register is unchanged, overrun=1 on the next cycle.
  - Exception: in the same cycle the holding register is loaded into the shift register, the write is accepted and hold_full stays 1.
- ovr_clr=1 clears overrun on the next cycle. If ovr_clr and a new overrun occur in the same cycle, overrun stays set.
- Each bit period is exactly 16 ticks. A 4-bit sample counter runs 0..15; the state or bit advances on the tick where sample==15, and sample then wraps to 0.
- IDLE: tx=1, tx_busy=0.
  - On a tick with hold_full=1: load the shift register from the holding register, hold_full=0, enter START.
  - tx=0 and tx_busy=1 from the next cycle.
- START: tx=0 for 16 ticks, then enter DATA with bitpos=0.
- DATA: tx = shift[bitpos] for 16 ticks per bit. bitpos increments at sample==15. After bit 7, enter PARITY if compiled in, otherwise STOP.
- PARITY (optional): tx = XOR of the 8 data bits, inverted when PARITY_ODD=1. Lasts 16 ticks, then enter STOP.
- STOP: tx=1 for 16*STOP_BITS ticks. On the final tick:
  - If hold_full=1: load immediately and go to START, with no idle bit between frames. tx_busy stays 1.
  - Otherwise: go to IDLE, tx_busy=0 on the next cycle.
- Frame length: 16*(10 + parity + STOP_BITS - 1) ticks.
- Reset mid-frame: tx returns to 1 immediately. The holding register contents are discarded.
- Illegal or unused state encodings go to IDLE with tx=1.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: the PARITY state exists and the frame carries 9 bits before stop, with sense set by PARITY_ODD.
- Undefined: no parity state, the 8N1/8N2 frame goes directly from DATA to STOP, and PARITY_ODD is unused.

Test Plan:
- Single byte: clken every cycle, tx_en=0, write 0xA5.
  - tx is 0 for 16 cycles, then bits 1,0,1,0,0,1,0,1, 16 cycles each, then 1.
  - tx_busy is high for 160 cycles; hold_full drops at frame start.
- Back-to-back: write 0x00, then 0xFF while the first frame is in START.
  - The second start bit begins on the tick right after the first stop bit ends, with no extra high time.
  - overrun=0.
- Overrun: write 0x11, 0x22 and 0x33 in consecutive cycles while a frame is active.
  - 0x22 is held, 0x33 is dropped, overrun=1.
  - ovr_clr pulse returns overrun to 0; the frames sent are 0x11 then 0x22.
- Enable gating: raise tx_en for 50 cycles in the middle of data bit 3.
  - tx holds the bit 3 value and the bit resumes with its remaining ticks.
  - Total frame is 160 ticks plus 50 paused cycles.
- Reset mid-frame: assert rst during DATA.
  - tx=1, tx_busy=0, hold_full=0 in the same cycle, asynchronously.
  - After release, writing 0x3C gives a clean frame.
- Parity (UART_TX_PARITY_EN, PARITY_ODD=0, STOP_BITS=2): write 0x07.
  - Parity bit is 1 and the stop time is 32 ticks high; frame is 192 ticks.
  - With PARITY_ODD=1 the parity bit is 0.
